// File: rtl/isl51002_pkg.sv
// isl51002_pkg
//   Shared definitions for the ISL51002 timing-mode controller:
//   lock / config state enums, hv_in_config* field positions as the
//   frontend decodes them, and the vtotal tolerance helper.
package isl51002_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      COUNTING = 2'd1,
      LOCKED   = 2'd2
   } lock_state_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } cfg_state_t;

   // hv_in_config (word0)
   localparam int unsigned H_TOTAL_LSB     = 0;
   localparam int unsigned H_TOTAL_MSB     = 11;
   localparam int unsigned H_ACTIVE_LSB    = 12;
   localparam int unsigned H_ACTIVE_MSB    = 22;
   localparam int unsigned H_BACKPORCH_LSB = 23;
   localparam int unsigned H_BACKPORCH_MSB = 31;
   // hv_in_config2 (word1)
   localparam int unsigned V_TOTAL_LSB     = 0;
   localparam int unsigned V_TOTAL_MSB     = 10;
   localparam int unsigned V_ACTIVE_LSB    = 11;
   localparam int unsigned V_ACTIVE_MSB    = 21;
   localparam int unsigned V_BACKPORCH_LSB = 22;
   localparam int unsigned V_BACKPORCH_MSB = 31;
   // hv_in_config3 (word2)
   localparam int unsigned H_SYNCLEN_LSB   = 0;
   localparam int unsigned H_SYNCLEN_MSB   = 7;
   localparam int unsigned V_SYNCLEN_LSB   = 8;
   localparam int unsigned V_SYNCLEN_MSB   = 15;
   localparam int unsigned H_SYNC_POL_BIT  = 16;
   localparam int unsigned V_SYNC_POL_BIT  = 17;

   // |a - b| <= tol, evaluated as a 12-bit signed difference.
   function automatic logic vtotal_within(input logic [10:0] a,
                                          input logic [10:0] b,
                                          input int unsigned tol);
      logic signed [11:0] diff;
      logic [11:0]        mag;
      diff = $signed({1'b0, a}) - $signed({1'b0, b});
      mag  = diff[11] ? 12'(-diff) : 12'(diff);
      return (32'(mag) <= tol);
   endfunction

endpackage

// File: rtl/isl51002_mode_ctrl_if.sv
// isl51002_mode_ctrl_if
//   CPU-side configuration handshake.
//   master (CPU):  drives cfg_wr_req (level) and cfg_word0..2,
//                  receives cfg_wr_ack (1-cycle pulse) and cfg_pending.
//   slave (ctrl):  the reverse.
interface isl51002_mode_ctrl_if;
   logic        cfg_wr_req;
   logic [31:0] cfg_word0;
   logic [31:0] cfg_word1;
   logic [31:0] cfg_word2;
   logic        cfg_wr_ack;
   logic        cfg_pending;

   modport master (
      output cfg_wr_req, cfg_word0, cfg_word1, cfg_word2,
      input  cfg_wr_ack, cfg_pending
   );

   modport slave (
      input  cfg_wr_req, cfg_word0, cfg_word1, cfg_word2,
      output cfg_wr_ack, cfg_pending
   );
endinterface

// File: rtl/isl51002_cfg_shadow.sv
// isl51002_cfg_shadow
//   Captures CPU config words into a shadow on a req/ack handshake and
//   copies them to hv_in_config* atomically at a frame boundary.
//   Ports: PCLK_i / reset_n (async, active-low); cfg (handshake slave);
//          fe (frame edge strobe); mode_locked (registered lock state);
//          hv_in_config / hv_in_config2 / hv_in_config3 (applied words).
module isl51002_cfg_shadow
   import isl51002_pkg::*;
(
   input  logic                        PCLK_i,
   input  logic                        reset_n,
   isl51002_mode_ctrl_if.slave         cfg,
   input  logic                        fe,
   input  logic                        mode_locked,
   output logic [31:0]                 hv_in_config,
   output logic [31:0]                 hv_in_config2,
   output logic [31:0]                 hv_in_config3
);

   cfg_state_t  state;
   logic [31:0] shadow0;
   logic [31:0] shadow1;
   logic [31:0] shadow2;
   logic        apply;

   // Unlocked: the ack cycle is skipped, so the copy lands two cycles
   // after the ack. Locked: wait for the next frame edge.
   assign apply = (fe & mode_locked) | (~mode_locked & ~cfg.cfg_wr_ack);

   always_ff @(posedge PCLK_i or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         shadow0         <= '0;
         shadow1         <= '0;
         shadow2         <= '0;
         hv_in_config    <= '0;
         hv_in_config2   <= '0;
         hv_in_config3   <= '0;
         cfg.cfg_wr_ack  <= 1'b0;
         cfg.cfg_pending <= 1'b0;
      end else begin
         cfg.cfg_wr_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg.cfg_wr_req) begin
                  shadow0         <= cfg.cfg_word0;
                  shadow1         <= cfg.cfg_word1;
                  shadow2         <= cfg.cfg_word2;
                  cfg.cfg_wr_ack  <= 1'b1;
                  cfg.cfg_pending <= 1'b1;
                  state           <= PENDING;
               end
            end
            PENDING: begin
               if (apply) begin
                  hv_in_config    <= shadow0;
                  hv_in_config2   <= shadow1;
                  hv_in_config3   <= shadow2;
                  cfg.cfg_pending <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/isl51002_mode_ctrl.sv
// isl51002_mode_ctrl
//   Timing-mode controller for the ISL51002 frontend (PCLK domain).
//   Qualifies mode stability from per-frame vtotal / interlace, drives
//   mode_locked and a sticky mode_irq, and owns hv_in_config*.
//   Ports: PCLK_i, reset_n (async, active-low); cfg (CPU handshake);
//          frame_change_i, vtotal_i, interlace_flag_i (frontend status);
//          hv_in_config* (applied config); mode_locked, mode_vtotal,
//          mode_irq (status); irq_clear (clears mode_irq).
module isl51002_mode_ctrl
   import isl51002_pkg::*;
#(
   parameter int unsigned STABLE_FRAMES = 3,
   parameter int unsigned VTOTAL_TOL    = 0,
   parameter logic [23:0] TIMEOUT_CYC   = 24'd4000000
) (
   input  logic                PCLK_i,
   input  logic                reset_n,
   isl51002_mode_ctrl_if.slave cfg,
   input  logic                frame_change_i,
   input  logic [10:0]         vtotal_i,
   input  logic                interlace_flag_i,
   output logic [31:0]         hv_in_config,
   output logic [31:0]         hv_in_config2,
   output logic [31:0]         hv_in_config3,
   output logic                mode_locked,
   output logic [10:0]         mode_vtotal,
   output logic                mode_irq,
   input  logic                irq_clear
);

   lock_state_t lock_state;
   logic        fc_prev;
   logic        fe;
   logic        ref_il;
   logic        match;
   logic [7:0]  stable_ctr;
   logic [23:0] to_ctr;
   logic        timeout_hit;
   logic        irq_set;

   assign fe    = frame_change_i & ~fc_prev;
   assign match = vtotal_within(vtotal_i, mode_vtotal, VTOTAL_TOL) &&
                  (interlace_flag_i == ref_il);

   // Fires once, on the cycle the counter reaches TIMEOUT_CYC; a frame
   // edge in that cycle takes precedence.
   assign timeout_hit = ~fe && (to_ctr == TIMEOUT_CYC - 24'd1);

   assign irq_set = (lock_state == LOCKED) &&
                    ((fe && !match) || timeout_hit);

   always_ff @(posedge PCLK_i or negedge reset_n) begin
      if (!reset_n) begin
         fc_prev     <= 1'b0;
         lock_state  <= UNLOCKED;
         stable_ctr  <= '0;
         to_ctr      <= '0;
         mode_locked <= 1'b0;
         mode_vtotal <= '0;
         ref_il      <= 1'b0;
         mode_irq    <= 1'b0;
      end else begin
         fc_prev <= frame_change_i;

         if (fe)
            to_ctr <= '0;
         else if (to_ctr != TIMEOUT_CYC)
            to_ctr <= to_ctr + 24'd1;

         if (fe) begin
            case (lock_state)
               UNLOCKED: begin
                  mode_vtotal <= vtotal_i;
                  ref_il      <= interlace_flag_i;
                  stable_ctr  <= '0;
                  lock_state  <= COUNTING;
               end
               COUNTING: begin
                  if (match) begin
                     if (stable_ctr == 8'(STABLE_FRAMES - 1)) begin
                        lock_state  <= LOCKED;
                        mode_locked <= 1'b1;
                     end else begin
                        stable_ctr <= stable_ctr + 8'd1;
                     end
                  end else begin
                     mode_vtotal <= vtotal_i;
                     ref_il      <= interlace_flag_i;
                     stable_ctr  <= '0;
                  end
               end
               LOCKED: begin
                  if (!match) begin
                     mode_vtotal <= vtotal_i;
                     ref_il      <= interlace_flag_i;
                     stable_ctr  <= '0;
                     lock_state  <= COUNTING;
                     mode_locked <= 1'b0;
                  end
               end
               default: begin
                  lock_state  <= UNLOCKED;
                  mode_locked <= 1'b0;
               end
            endcase
         end else if (timeout_hit) begin
            lock_state  <= UNLOCKED;
            stable_ctr  <= '0;
            mode_locked <= 1'b0;
         end

         if (irq_set)
            mode_irq <= 1'b1;
         else if (irq_clear)
            mode_irq <= 1'b0;
      end
   end

   isl51002_cfg_shadow u_cfg_shadow (
      .PCLK_i        (PCLK_i),
      .reset_n       (reset_n),
      .cfg           (cfg),
      .fe            (fe),
      .mode_locked   (mode_locked),
      .hv_in_config  (hv_in_config),
      .hv_in_config2 (hv_in_config2),
      .hv_in_config3 (hv_in_config3)
   );

endmodule

// File: tb/tb_isl51002_mode_ctrl.sv
// tb_isl51002_mode_ctrl
//   Scoreboard bench: each stimulus cycle the reference model predicts
//   the registered outputs after the next clock edge and queues them;
//   a monitor pops and compares one entry per clock edge.
module tb_isl51002_mode_ctrl;

   localparam int SF  = 3;
   localparam int TOL = 1;
   localparam int TO  = 1000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_change_i;
   logic [10:0] vtotal_i;
   logic        interlace_flag_i;
   logic        irq_clear;
   logic [31:0] hv0, hv1, hv2;
   logic        mode_locked;
   logic [10:0] mode_vtotal;
   logic        mode_irq;

   isl51002_mode_ctrl_if cfg_if ();

   isl51002_mode_ctrl #(
      .STABLE_FRAMES (SF),
      .VTOTAL_TOL    (TOL),
      .TIMEOUT_CYC   (24'(TO))
   ) dut (
      .PCLK_i           (clk),
      .reset_n          (reset_n),
      .cfg              (cfg_if),
      .frame_change_i   (frame_change_i),
      .vtotal_i         (vtotal_i),
      .interlace_flag_i (interlace_flag_i),
      .hv_in_config     (hv0),
      .hv_in_config2    (hv1),
      .hv_in_config3    (hv2),
      .mode_locked      (mode_locked),
      .mode_vtotal      (mode_vtotal),
      .mode_irq         (mode_irq),
      .irq_clear        (irq_clear)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit rnd_en = 0;

   logic [110:0] exp_q[$];

   // ---------------- reference model ----------------
   bit          m_fc_prev, m_have_ref, m_locked, m_irq, m_il;
   bit          m_ack, m_pend;
   int          m_vt, m_matches, m_idle;
   logic [31:0] m_sh [0:2];
   logic [31:0] m_out[0:2];

   function automatic void model_reset();
      m_fc_prev = 0; m_have_ref = 0; m_locked = 0; m_irq = 0; m_il = 0;
      m_ack = 0; m_pend = 0; m_vt = 0; m_matches = 0; m_idle = 0;
      for (int i = 0; i < 3; i++) begin
         m_sh[i]  = '0;
         m_out[i] = '0;
      end
   endfunction

   function automatic logic [110:0] model_vec();
      return {m_ack, m_pend, m_locked, m_irq, 11'(m_vt),
              m_out[0], m_out[1], m_out[2]};
   endfunction

   function automatic logic [110:0] dut_vec();
      return {cfg_if.cfg_wr_ack, cfg_if.cfg_pending, mode_locked, mode_irq,
              mode_vtotal, hv0, hv1, hv2};
   endfunction

   // One clock of the specification's rules, from the inputs now applied.
   function automatic void model_step();
      bit edge_, match, was_locked, was_ack, irq_set;
      int d;
      edge_      = frame_change_i && !m_fc_prev;
      m_fc_prev  = frame_change_i;
      d          = int'(vtotal_i) - m_vt;
      if (d < 0) d = -d;
      match      = (d <= TOL) && (interlace_flag_i == m_il);
      was_locked = m_locked;
      was_ack    = m_ack;
      irq_set    = 0;

      if (edge_) begin
         m_idle = 0;
         if (!m_have_ref) begin
            m_have_ref = 1; m_vt = int'(vtotal_i); m_il = interlace_flag_i;
            m_matches = 0;
         end else if (match) begin
            if (!m_locked) begin
               m_matches++;
               if (m_matches >= SF) m_locked = 1;
            end
         end else begin
            irq_set = m_locked;
            m_locked = 0; m_vt = int'(vtotal_i); m_il = interlace_flag_i;
            m_matches = 0;
         end
      end else begin
         if (m_idle == TO - 1) begin
            irq_set = m_locked;
            m_locked = 0; m_have_ref = 0; m_matches = 0;
         end
         if (m_idle < TO) m_idle++;
      end

      if (irq_set)        m_irq = 1;
      else if (irq_clear) m_irq = 0;

      m_ack = 0;
      if (!m_pend) begin
         if (cfg_if.cfg_wr_req) begin
            m_sh[0] = cfg_if.cfg_word0;
            m_sh[1] = cfg_if.cfg_word1;
            m_sh[2] = cfg_if.cfg_word2;
            m_ack = 1; m_pend = 1;
         end
      end else if ((edge_ && was_locked) || (!was_locked && !was_ack)) begin
         for (int i = 0; i < 3; i++) m_out[i] = m_sh[i];
         m_pend = 0;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      if (rnd_en) begin
         irq_clear = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) begin
            cfg_if.cfg_wr_req = ~cfg_if.cfg_wr_req;
            cfg_if.cfg_word0  = $urandom();
            cfg_if.cfg_word1  = $urandom();
            cfg_if.cfg_word2  = $urandom();
         end
      end
      model_step();
      exp_q.push_back(model_vec());
      @(negedge clk);
   endtask

   task automatic frame(input int vt, input bit il, input int hi, input int gap);
      vtotal_i         = 11'(vt);
      interlace_flag_i = il;
      frame_change_i   = 1'b1;
      repeat (hi) tick();
      frame_change_i   = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic cfg_write(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2);
      cfg_if.cfg_wr_req = 1'b1;
      cfg_if.cfg_word0  = w0;
      cfg_if.cfg_word1  = w1;
      cfg_if.cfg_word2  = w2;
      tick();
      cfg_if.cfg_wr_req = 1'b0;
   endtask

   task automatic do_reset();
      cfg_if.cfg_wr_req = 1'b0;
      irq_clear         = 1'b0;
      frame_change_i    = 1'b0;
      reset_n           = 1'b0;
      #1;
      checks++;
      if (dut_vec() != '0) begin
         errors++;
         $display("FAIL async_reset got=%h want=0", dut_vec());
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [110:0] exp;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec() !== exp) begin
               errors++;
               $display("FAIL outputs cyc=%0d got ack/pend/lock/irq/vt/cfg=%h want=%h",
                        cyc, dut_vec(), exp);
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      reset_n           = 1'b0;
      frame_change_i    = 1'b0;
      vtotal_i          = '0;
      interlace_flag_i  = 1'b0;
      irq_clear         = 1'b0;
      cfg_if.cfg_wr_req = 1'b0;
      cfg_if.cfg_word0  = '0;
      cfg_if.cfg_word1  = '0;
      cfg_if.cfg_word2  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (dut_vec() !== '0) begin
         errors++;
         $display("FAIL reset_values got=%h want=0", dut_vec());
      end
      reset_n = 1'b1;

      // lock-up at 525
      repeat (5) frame(525, 0, 2, 25);

      // config while locked, second request during PENDING ignored
      frame(525, 0, 1, 5);
      cfg_write(32'h1, 32'h2, 32'h3);
      repeat (3) tick();
      cfg_if.cfg_wr_req = 1'b1;
      cfg_if.cfg_word0  = 32'hAAAA_0001;
      cfg_if.cfg_word1  = 32'hAAAA_0002;
      cfg_if.cfg_word2  = 32'hAAAA_0003;
      repeat (2) tick();
      cfg_if.cfg_wr_req = 1'b0;
      repeat (5) tick();
      frame(525, 0, 2, 20);

      // mode change, irq clear, relock at 625
      frame(625, 0, 2, 10);
      irq_clear = 1'b1; tick(); irq_clear = 1'b0;
      repeat (4) frame(625, 0, 3, 20);

      // tolerance window around 525, then a jump out of it
      frame(525, 0, 1, 15);
      irq_clear = 1'b1; tick(); irq_clear = 1'b0;
      for (int i = 0; i < 7; i++) frame((i % 2 == 0) ? 524 : 525, 0, 1, 15);
      frame(527, 0, 1, 15);

      // interlace flag change breaks lock
      repeat (4) frame(527, 0, 2, 15);
      frame(527, 1, 2, 15);

      // timeout while locked
      repeat (4) frame(525, 0, 2, 15);
      repeat (TO + 10) tick();
      irq_clear = 1'b1; tick(); irq_clear = 1'b0;

      // config while unlocked
      cfg_write(32'h11, 32'h22, 32'h33);
      repeat (4) tick();

      // frame edge coinciding with the timeout cycle keeps the lock
      repeat (4) frame(525, 0, 2, 15);
      frame(525, 0, 1, TO - 1);
      frame(525, 0, 1, 20);

      // reset while PENDING (locked): shadow discarded
      cfg_write(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002);
      tick();
      do_reset();
      repeat (10) tick();

      // reset in the ack cycle while unlocked
      cfg_write(32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002);
      do_reset();
      repeat (6) tick();

      // randomized traffic
      rnd_en = 1;
      for (int n = 0; n < 60; n++) begin
         int sel;
         sel = int'($urandom_range(0, 5));
         frame((sel < 3) ? 525 : (sel == 3) ? 526 : (sel == 4) ? 527 : 625,
               ($urandom_range(0, 9) == 0), int'($urandom_range(1, 3)),
               int'($urandom_range(10, 40)));
      end
      rnd_en = 0;
      irq_clear = 1'b0;
      cfg_if.cfg_wr_req = 1'b0;
      repeat (5) tick();

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
